// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz VGA timing constants and the pixel coordinate type.
package vga_timing_pkg;

    localparam int unsigned CLK_DIV   = 4;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;

    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef logic [9:0] vga_coord_t;

endpackage

// File: rtl/pixel_clk_div.sv
// Pixel-rate enable: a one-cycle pulse every CLK_DIV system clocks.
module pixel_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic pix_tick
);

    // Keep at least one bit so CLK_DIV=1 still has a (constant-zero) counter.
    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] div_cnt_q;
    logic [DivW-1:0] div_cnt_d;

    assign pix_tick = (div_cnt_q == DivLast);

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (pix_tick) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/vga_decoder.sv
// VGA timing generator: pixel-rate h/v counters with combinational sync, DE and
// coordinate decode.
module vga_decoder
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV   = vga_timing_pkg::CLK_DIV,
    parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FP      = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP      = vga_timing_pkg::H_BP,
    parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FP      = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP      = vga_timing_pkg::V_BP
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       pix_tick,
    output logic       h_sync,
    output logic       v_sync,
    output logic       DE,
    output logic [9:0] x_pixel,
    output logic [9:0] y_pixel,
    output logic       frame_start
);

    localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam vga_coord_t HLast = vga_coord_t'(HTotal - 1);
    localparam vga_coord_t VLast = vga_coord_t'(VTotal - 1);

    // Range bounds are 11 bits so a segment edge of exactly 1024 still compares correctly.
    localparam logic [10:0] HVisEnd    = 11'(H_VISIBLE);
    localparam logic [10:0] VVisEnd    = 11'(V_VISIBLE);
    localparam logic [10:0] HSyncStart = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HSyncEnd   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] VSyncStart = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VSyncEnd   = 11'(V_VISIBLE + V_FP + V_SYNC);

    vga_coord_t h_cnt_q, h_cnt_d;
    vga_coord_t v_cnt_q, v_cnt_d;
    logic [10:0] h_ext;
    logic [10:0] v_ext;

    pixel_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_clk_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .pix_tick (pix_tick)
    );

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_tick) begin
            if (h_cnt_q == HLast) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_ext = {1'b0, h_cnt_q};
    assign v_ext = {1'b0, v_cnt_q};

    assign x_pixel     = h_cnt_q;
    assign y_pixel     = v_cnt_q;
    assign DE          = (h_ext < HVisEnd) && (v_ext < VVisEnd);
    assign h_sync      = !((h_ext >= HSyncStart) && (h_ext < HSyncEnd));
    assign v_sync      = !((v_ext >= VSyncStart) && (v_ext < VSyncEnd));
    assign frame_start = pix_tick && (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: tb/tb_vga_decoder.sv
// Bench for vga_decoder: default timing plus CLK_DIV=1/2 and a shrunken frame.
module tb_vga_decoder;

    logic clk;
    logic reset_n;

    logic       t4, hs4, vs4, de4, fs4;
    logic [9:0] x4, y4;
    logic       t1, hs1, vs1, de1, fs1;
    logic [9:0] x1, y1;
    logic       t2, hs2, vs2, de2, fs2;
    logic [9:0] x2, y2;
    logic       ts, hss, vss, des, fss;
    logic [9:0] xs, ys;

    vga_decoder u_dut (
        .clk (clk), .reset_n (reset_n), .pix_tick (t4), .h_sync (hs4), .v_sync (vs4),
        .DE (de4), .x_pixel (x4), .y_pixel (y4), .frame_start (fs4)
    );

    vga_decoder #(.CLK_DIV (1)) u_div1 (
        .clk (clk), .reset_n (reset_n), .pix_tick (t1), .h_sync (hs1), .v_sync (vs1),
        .DE (de1), .x_pixel (x1), .y_pixel (y1), .frame_start (fs1)
    );

    vga_decoder #(.CLK_DIV (2)) u_div2 (
        .clk (clk), .reset_n (reset_n), .pix_tick (t2), .h_sync (hs2), .v_sync (vs2),
        .DE (de2), .x_pixel (x2), .y_pixel (y2), .frame_start (fs2)
    );

    // 15x8 frame (visible 8x4, hsync 10..12, vsync lines 5..6), 2 clocks per pixel.
    vga_decoder #(
        .CLK_DIV (2), .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_VISIBLE (4), .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) u_small (
        .clk (clk), .reset_n (reset_n), .pix_tick (ts), .h_sync (hss), .v_sync (vss),
        .DE (des), .x_pixel (xs), .y_pixel (ys), .frame_start (fss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Expected behaviour from elapsed cycles since reset release.
    task automatic chk_model(input string tag, input int c, input int div, input int ht,
                             input int vt, input int hv, input int vv, input int hs0,
                             input int hs1e, input int vs0, input int vs1e, input logic tick,
                             input logic [9:0] x, input logic [9:0] y, input logic de,
                             input logic hs, input logic vs, input logic fs);
        int px, ex, ey, et;
        px = c / div;
        ex = px % ht;
        ey = (px / ht) % vt;
        et = ((c % div) == (div - 1)) ? 1 : 0;
        chk({tag, ".tick"}, int'(tick), et);
        chk({tag, ".x"}, int'(x), ex);
        chk({tag, ".y"}, int'(y), ey);
        chk({tag, ".de"}, int'(de), (ex < hv && ey < vv) ? 1 : 0);
        chk({tag, ".hsync"}, int'(hs), (ex >= hs0 && ex < hs1e) ? 0 : 1);
        chk({tag, ".vsync"}, int'(vs), (ey >= vs0 && ey < vs1e) ? 0 : 1);
        chk({tag, ".fstart"}, int'(fs), (et == 1 && ex == 0 && ey == 0) ? 1 : 0);
    endtask

    typedef struct {
        int   cyc;
        logic tick;
        int   x;
        int   y;
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } vec_t;

    localparam int NVec = 13;
    vec_t vecs[NVec];

    int hs_low_cnt, de_cnt, vs_low_s, de_s, fs_s_cnt, fs_s_first, fs_s_second, vi;

    initial begin
        vecs[0]  = '{0,    1'b0, 0,   0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{3,    1'b1, 0,   0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{4,    1'b0, 1,   0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{7,    1'b1, 1,   0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{2559, 1'b1, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{2560, 1'b0, 640, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{2623, 1'b1, 655, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{2624, 1'b0, 656, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{3007, 1'b1, 751, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{3008, 1'b0, 752, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{3199, 1'b1, 799, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{3200, 1'b0, 0,   1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{3203, 1'b1, 0,   1, 1'b1, 1'b1, 1'b1, 1'b1 & 1'b0};

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        hs_low_cnt = 0; de_cnt = 0; vs_low_s = 0; de_s = 0;
        fs_s_cnt = 0; fs_s_first = -1; fs_s_second = -1; vi = 0;

        for (int c = 0; c <= 4400; c++) begin
            if (c > 0) @(negedge clk);
            cyc = c;
            if (vi < NVec && vecs[vi].cyc == c) begin
                chk("vec.tick", int'(t4), int'(vecs[vi].tick));
                chk("vec.x", int'(x4), vecs[vi].x);
                chk("vec.y", int'(y4), vecs[vi].y);
                chk("vec.de", int'(de4), int'(vecs[vi].de));
                chk("vec.hsync", int'(hs4), int'(vecs[vi].hs));
                chk("vec.vsync", int'(vs4), int'(vecs[vi].vs));
                chk("vec.fstart", int'(fs4), int'(vecs[vi].fs));
                vi++;
            end
            if (c < 3200) begin
                if (!hs4) hs_low_cnt++;
                if (de4) de_cnt++;
            end
            if (c < 1700) begin
                chk_model("div1", c, 1, 800, 525, 640, 480, 656, 752, 490, 492,
                          t1, x1, y1, de1, hs1, vs1, fs1);
                chk_model("div2", c, 2, 800, 525, 640, 480, 656, 752, 490, 492,
                          t2, x2, y2, de2, hs2, vs2, fs2);
            end
            if (c < 480) begin
                chk_model("small", c, 2, 15, 8, 8, 4, 10, 13, 5, 7,
                          ts, xs, ys, des, hss, vss, fss);
                if (c < 240) begin
                    if (!vss) vs_low_s++;
                    if (des) de_s++;
                end
                if (fss) begin
                    fs_s_cnt++;
                    if (fs_s_first < 0) fs_s_first = c;
                    else if (fs_s_second < 0) fs_s_second = c;
                end
            end
            if (c == 239) begin
                chk("small.wrap_x_before", int'(xs), 14);
                chk("small.wrap_y_before", int'(ys), 7);
            end
            if (c == 240) begin
                chk("small.wrap_x_after", int'(xs), 0);
                chk("small.wrap_y_after", int'(ys), 0);
            end
        end

        chk("hsync_low_cycles", hs_low_cnt, 384);
        chk("de_high_cycles_line0", de_cnt, 2560);
        chk("small.vsync_low_cycles", vs_low_s, 60);
        chk("small.de_high_cycles", de_s, 64);
        chk("small.fstart_count", fs_s_cnt, 2);
        chk("small.fstart_first", fs_s_first, 1);
        chk("small.fstart_spacing", fs_s_second - fs_s_first, 240);

        // Mid-frame: default at (300,1), small at (10,2).
        chk("pre_reset.x", int'(x4), 300);
        chk("pre_reset.y", int'(y4), 1);
        chk("pre_reset.small_y", int'(ys), 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset.x", int'(x4), 0);
        chk("async_reset.y", int'(y4), 0);
        chk("async_reset.hsync", int'(hs4), 1);
        chk("async_reset.vsync", int'(vs4), 1);
        chk("async_reset.de", int'(de4), 1);
        chk("async_reset.tick", int'(t4), 0);
        chk("async_reset.fstart", int'(fs4), 0);
        chk("async_reset.small_x", int'(xs), 0);
        chk("async_reset.small_y", int'(ys), 0);
        chk("async_reset.div1_tick", int'(t1), 1);
        repeat (2) @(negedge clk);
        chk("held_reset.x", int'(x4), 0);
        chk("held_reset.tick", int'(t4), 0);
        reset_n = 1'b1;

        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            cyc = c;
            chk("cadence.tick", int'(t4), ((c % 4) == 3) ? 1 : 0);
            chk("cadence.x", int'(x4), c / 4);
            chk("cadence.y", int'(y4), 0);
            chk("cadence.fstart", int'(fs4), (c == 3) ? 1 : 0);
            chk("cadence.small_x", int'(xs), (c / 2) % 15);
            chk("cadence.small_y", int'(ys), (c / 30) % 8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
